// File: rtl/seq_controller.sv
// seq_controller: VeriRisc 8-phase sequencing controller with opcode decode,
// memory wait-state stalls, sticky halt/resume and illegal-opcode detection.
// Build option: define SEQCTL_TIMEOUT_EN to add the bus-timeout watchdog
// (stall counter plus sticky timeout port).
module seq_controller #(
  parameter int OPC_W          = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             resume,
  output logic [2:0]       phase,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             halt,
  output logic             ld_pc,
  output logic             data_e,
  output logic             ld_ac,
  output logic             wr,
  output logic             halted,
  output logic             illegal
`ifdef SEQCTL_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  typedef enum logic [2:0] {
    PH0 = 3'd0,
    PH1 = 3'd1,
    PH2 = 3'd2,
    PH3 = 3'd3,
    PH4 = 3'd4,
    PH5 = 3'd5,
    PH6 = 3'd6,
    PH7 = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Opcode classification; every class is qualified by op_legal so that an
  // illegal code never decodes as one of the eight real instructions.
  logic [2:0] op_low;
  logic       op_legal;
  logic       op_hlt;
  logic       op_skz;
  logic       op_sto;
  logic       op_jmp;
  logic       op_alu;

  phase_t phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   illegal_q, illegal_d;
  logic   stall_phase;
  logic   waiting;
  logic   advance;

`ifdef SEQCTL_TIMEOUT_EN
  // Counter only needs to hold 0..TIMEOUT_CYCLES-1: the cycle that would
  // reach TIMEOUT_CYCLES forces the advance and clears it instead.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             timeout_q, timeout_d;
  logic             expire;
`else
  // TIMEOUT_CYCLES only sizes the watchdog, which this build leaves out.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  assign op_low = opcode[2:0];

  // Codes 8 and above exist only when the opcode field is wider than 3 bits.
  generate
    if (OPC_W > 3) begin : g_wide_opc
      assign op_legal = ~|opcode[OPC_W-1:3];
    end else begin : g_narrow_opc
      assign op_legal = 1'b1;
    end
  endgenerate

  // Instruction class decode from the instantaneous opcode.
  always_comb begin
    op_hlt = op_legal && (op_low == OP_HLT);
    op_skz = op_legal && (op_low == OP_SKZ);
    op_sto = op_legal && (op_low == OP_STO);
    op_jmp = op_legal && (op_low == OP_JMP);
    op_alu = op_legal && ((op_low == OP_ADD) || (op_low == OP_AND) ||
                          (op_low == OP_XOR) || (op_low == OP_LDA));
  end

  // Next-state logic: phase advance, stall hold, halt/resume, sticky flags.
  always_comb begin
    // ph3 is the instruction fetch access; ph7 is the operand access for
    // instructions that actually touch memory in their last phase.
    stall_phase = (phase_q == PH3) || ((phase_q == PH7) && (op_alu || op_sto));
    waiting     = stall_phase && !mem_ready;

`ifdef SEQCTL_TIMEOUT_EN
    expire  = waiting && (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    advance = !halted_q && (!waiting || expire);
`else
    advance = !halted_q && !waiting;
`endif

    phase_d = advance ? phase_t'(phase_q + 3'd1) : phase_q;

    // Resume is only honoured while already halted; halt entry at ph4 is
    // evaluated afterwards so it wins over a coincident resume.
    halted_d = halted_q;
    if (halted_q && resume) begin
      halted_d = 1'b0;
    end
    if (!halted_q && (phase_q == PH4) && op_hlt) begin
      halted_d = 1'b1;
    end

    illegal_d = illegal_q || (!halted_q && (phase_q == PH4) && !op_legal);

`ifdef SEQCTL_TIMEOUT_EN
    timeout_d = timeout_q || expire;
    if (advance) begin
      stall_cnt_d = '0;
    end else if (waiting) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
`endif
  end

  // State registers; reset returns straight to ph0 and drops any pending access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= PH0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef SEQCTL_TIMEOUT_EN
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
`endif
    end else begin
      phase_q     <= phase_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
`ifdef SEQCTL_TIMEOUT_EN
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  // Control decode from phase and opcode; everything is forced low while halted.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    if (!halted_q) begin
      case (phase_q)
        PH0: begin
          sel = 1'b1;
        end
        PH1: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH2, PH3: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH4: begin
          inc_pc = 1'b1;
          halt   = op_hlt;
        end
        PH5: begin
          rd = op_alu;
        end
        PH6: begin
          rd     = op_alu;
          inc_pc = op_skz && zero;
          ld_pc  = op_jmp;
          data_e = op_sto;
        end
        PH7: begin
          rd     = op_alu;
          ld_ac  = op_alu;
          ld_pc  = op_jmp;
          data_e = op_sto;
          wr     = op_sto;
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  assign phase   = phase_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;
`ifdef SEQCTL_TIMEOUT_EN
  assign timeout = timeout_q;
`endif

endmodule

// File: doc/seq_controller.md
Name: seq_controller

Overview:
- Next-generation VeriRisc sequencing controller: merges the 8-phase phase counter with the opcode decoder.
- Adds four things over the combinational controller: memory wait-state stalls, a sticky halt with resume, and illegal-opcode detection for widened opcodes. A bus-timeout watchdog is available as a compile option.
- Sits between the instruction register/accumulator and the memory/PC/AC datapath of the CPU.

Parameters:
- OPC_W, 3, opcode width (>=3). Codes 0..7 are HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP; codes >=8 are illegal.
- TIMEOUT_CYCLES, 16, consecutive stall cycles before timeout. Used only when SEQCTL_TIMEOUT_EN is defined; must be >=1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  OPC_W  instruction register opcode field
- zero  in  1  accumulator is zero
- mem_ready  in  1  memory completes the current access this cycle
- resume  in  1  clears the halted state
- phase  out  3  current phase, 0..7
- sel  out  1  select PC as memory address
- rd  out  1  memory read enable
- ld_ir  out  1  load instruction register
- inc_pc  out  1  increment PC
- halt  out  1  halt pulse (phase 4 of HLT)
- ld_pc  out  1  load PC
- data_e  out  1  drive AC onto data bus
- ld_ac  out  1  load AC
- wr  out  1  memory write
- halted  out  1  sticky halt status
- illegal  out  1  sticky illegal-opcode flag
- timeout  out  1  sticky timeout flag; present only with SEQCTL_TIMEOUT_EN

Behaviour:
- Reset (async, rst=1): phase=0, halted=0, illegal=0, timeout=0, stall counter=0. The decoded outputs follow from phase 0, so sel=1 and all others 0.
- Decode is combinational from (phase, opcode, zero, halted):
  - ph0: sel
  - ph1: sel, rd
  - ph2, ph3: sel, rd, ld_ir
  - ph4: inc_pc, plus halt if opcode==HLT
  - ph5: rd if ALU-op
  - ph6: rd if ALU-op; inc_pc if SKZ and zero; ld_pc if JMP; data_e if STO
  - ph7: rd and ld_ac if ALU-op; ld_pc if JMP; data_e and wr if STO
  - ALU-op means ADD, AND, XOR or LDA.
- Illegal opcode (>=8): fetch phases 0..3 decode normally.
  - ph4 asserts inc_pc only; execute phases 5..7 assert nothing.
  - illegal sets at the clk edge ending ph4 and stays set until rst.
- Phase advance: phase increments mod 8 on each clk edge unless stalled or halted. 7 wraps to 0.
- Stall:
  - Stall phases are ph3, plus ph7 when the opcode is ALU-op or STO.
  - In a stall phase with mem_ready=0, phase holds and all outputs stay constant.
  - mem_ready=1 lets phase advance on that edge.
  - mem_ready is ignored in all other phases.
- Halt:
  - At the edge ending ph4 with opcode==HLT, halted sets and phase advances to 5.
  - While halted, phase freezes at 5 and all decoded outputs are 0.
  - resume=1 on an edge clears halted; phase advances to 6 on the following edge.
  - resume while not halted: no effect.
  - Simultaneous halt entry and resume: halt wins, resume is ignored that cycle.
- The opcode may change only at the ph3 to ph4 boundary; decode uses the instantaneous opcode.
- Reset mid-stall or mid-halt: immediate return to the reset state. No partial access is recorded.

Optional Feature:
- Macro SEQCTL_TIMEOUT_EN.
- Defined:
  - The stall counter counts consecutive stalled cycles and clears whenever phase advances.
  - When the count reaches TIMEOUT_CYCLES, timeout sets (sticky until rst) and phase is forced to advance as if mem_ready=1.
  - timeout port exists.
- Undefined:
  - No counter, no timeout port.
  - Stalls may last indefinitely.

Test Plan:
1. rst pulse, then LDA with mem_ready=1 over 8 clocks -> phase 0..7; outputs match: sel; sel,rd; sel,rd,ld_ir x2; inc_pc; rd; rd; rd,ld_ac. Phase wraps to 0.
2. STO with mem_ready=0 for 3 cycles at ph7 -> phase holds 7 with data_e=wr=1 for 4 cycles total, then 0.
3. HLT -> ph4 gives inc_pc=halt=1; then halted=1, phase=5, all outputs 0 for 10 cycles. Pulse resume -> halted=0, then phase 6, 7, 0.
4. SKZ with zero=1 -> inc_pc at ph4 and ph6. With zero=0 -> inc_pc at ph4 only. JMP -> ld_pc at ph6 and ph7.
5. OPC_W=4, opcode=9 -> ph4 inc_pc only; ph5..7 all outputs 0; illegal=1 from ph5 until rst.
6. SEQCTL_TIMEOUT_EN, TIMEOUT_CYCLES=4, ADD with mem_ready=0 at ph3 -> 4 stalled cycles, then timeout=1 and phase=4. Assert rst mid-stall -> phase=0, timeout=0 immediately.
